// File: rtl/jelly2_axi4s_arbiter_pkg.sv
// Shared types for the packet-granular AXI4-Stream arbiter family.
// Contents: arbitration FSM state encoding.
// Imported by the arbiter top and any future arbiter variants.
package jelly2_axi4s_arbiter_pkg;

  // IDLE: free to pick any requester. BUSY: grant locked until tlast is accepted.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

endpackage

// File: rtl/jelly2_axi4s_packet_arbiter_if.sv
// Bundle of slave-side (NUM packed ports) and master-side AXI4-Stream signals
// around the packet arbiter.
// Modports: slave = arbiter view, master = environment view (sources + sink).
interface jelly2_axi4s_packet_arbiter_if #(
  parameter int NUM         = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int TUSER_BITS  = 1,
  parameter int SEL_WIDTH   = (NUM > 1) ? $clog2(NUM) : 1
);

  logic [NUM*TDATA_WIDTH-1:0] s_axi4s_tdata;
  logic [NUM*TSTRB_WIDTH-1:0] s_axi4s_tstrb;
  logic [NUM-1:0]             s_axi4s_tlast;
  logic [NUM*TUSER_BITS-1:0]  s_axi4s_tuser;
  logic [NUM-1:0]             s_axi4s_tvalid;
  logic [NUM-1:0]             s_axi4s_tready;

  logic [TDATA_WIDTH-1:0]     m_axi4s_tdata;
  logic [TSTRB_WIDTH-1:0]     m_axi4s_tstrb;
  logic                       m_axi4s_tfirst;
  logic                       m_axi4s_tlast;
  logic [TUSER_BITS-1:0]      m_axi4s_tuser;
  logic [SEL_WIDTH-1:0]       m_axi4s_tsel;
  logic                       m_axi4s_tvalid;
  logic                       m_axi4s_tready;

  modport slave (
    input  s_axi4s_tdata, s_axi4s_tstrb, s_axi4s_tlast, s_axi4s_tuser, s_axi4s_tvalid,
    output s_axi4s_tready,
    output m_axi4s_tdata, m_axi4s_tstrb, m_axi4s_tfirst, m_axi4s_tlast, m_axi4s_tuser,
    output m_axi4s_tsel, m_axi4s_tvalid,
    input  m_axi4s_tready
  );

  modport master (
    output s_axi4s_tdata, s_axi4s_tstrb, s_axi4s_tlast, s_axi4s_tuser, s_axi4s_tvalid,
    input  s_axi4s_tready,
    input  m_axi4s_tdata, m_axi4s_tstrb, m_axi4s_tfirst, m_axi4s_tlast, m_axi4s_tuser,
    input  m_axi4s_tsel, m_axi4s_tvalid,
    output m_axi4s_tready
  );

endinterface

// File: rtl/jelly2_round_robin_picker.sv
// Combinational round-robin picker: first asserted req searching ptr, ptr+1, ... mod NUM.
// Ports: req (NUM requests), ptr (search start), found (any req), index (winner).
// Zero latency; no state, so no backpressure of its own.
module jelly2_round_robin_picker #(
  parameter int NUM       = 4,
  parameter int SEL_WIDTH = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [NUM-1:0]       req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] index
);

  logic [SEL_WIDTH-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      cand = SEL_WIDTH'((int'(ptr) + k) % NUM);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/jelly2_axi4s_packet_arbiter.sv
// Packet-granular N:1 AXI4-Stream round-robin arbiter; grant held until tlast is accepted.
// Ports: aclk/aresetn (sync, active-low)/aclken, bus (slave-side ports + master output), busy.
// One registered output stage (1-cycle latency, full rate); only s_axi4s_tready is combinational.
module jelly2_axi4s_packet_arbiter
  import jelly2_axi4s_arbiter_pkg::*;
#(
  parameter int NUM         = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int TUSER_WIDTH = 0,
  parameter bit HAS_LAST    = 1'b1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic aclken,
  jelly2_axi4s_packet_arbiter_if.slave bus,
  output logic busy
);

  localparam int TUSER_BITS = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
  localparam int SEL_WIDTH  = (NUM > 1) ? $clog2(NUM) : 1;

  arb_state_t           state;
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] rr_ptr;

  logic                 found;
  logic [SEL_WIDTH-1:0] pick;
  logic [SEL_WIDTH-1:0] sel;
  logic                 out_ready;
  logic                 accept;
  logic [NUM-1:0]       ready;

  logic [TDATA_WIDTH-1:0] sel_data;
  logic [TSTRB_WIDTH-1:0] sel_strb;
  logic [TUSER_BITS-1:0]  sel_user;
  logic                   sel_last;
  logic                   sel_valid;

  logic [TDATA_WIDTH-1:0] out_data;
  logic [TSTRB_WIDTH-1:0] out_strb;
  logic [TUSER_BITS-1:0]  out_user;
  logic                   out_first;
  logic                   out_last;
  logic [SEL_WIDTH-1:0]   out_sel;
  logic                   out_valid;

  function automatic logic [SEL_WIDTH-1:0] next_ptr(input logic [SEL_WIDTH-1:0] idx);
    return (int'(idx) >= NUM - 1) ? '0 : idx + 1'b1;
  endfunction

  jelly2_round_robin_picker #(
    .NUM       (NUM),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_picker (
    .req   (bus.s_axi4s_tvalid),
    .ptr   (rr_ptr),
    .found (found),
    .index (pick)
  );

  assign sel       = (state == BUSY) ? grant : pick;
  assign out_ready = !out_valid || bus.m_axi4s_tready;

  assign sel_data  = bus.s_axi4s_tdata[int'(sel)*TDATA_WIDTH +: TDATA_WIDTH];
  assign sel_strb  = bus.s_axi4s_tstrb[int'(sel)*TSTRB_WIDTH +: TSTRB_WIDTH];
  // With no user field the 1-bit user input is ignored and the output stays 0.
  assign sel_user  = (TUSER_WIDTH > 0) ? bus.s_axi4s_tuser[int'(sel)*TUSER_BITS +: TUSER_BITS] : '0;
  // Without tlast every beat is its own packet.
  assign sel_last  = HAS_LAST ? bus.s_axi4s_tlast[sel] : 1'b1;
  assign sel_valid = bus.s_axi4s_tvalid[sel];

  // In BUSY the granted port keeps tready even if it has dropped tvalid between beats.
  always_comb begin
    ready = '0;
    if (aclken && out_ready && (state == BUSY || found)) begin
      ready[sel] = 1'b1;
    end
  end

  assign accept = aclken && out_ready && (state == BUSY || found) && sel_valid;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      out_data  <= '0;
      out_strb  <= '0;
      out_user  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (aclken) begin
      if (accept) begin
        out_data  <= sel_data;
        out_strb  <= sel_strb;
        out_user  <= sel_user;
        out_last  <= sel_last;
        out_sel   <= sel;
        out_first <= (state == IDLE);
        out_valid <= 1'b1;
        if (state == IDLE) begin
          if (!sel_last) begin
            state <= BUSY;
            grant <= pick;
          end else begin
            rr_ptr <= next_ptr(pick);
          end
        end else if (sel_last) begin
          state  <= IDLE;
          rr_ptr <= next_ptr(grant);
        end
      end else if (bus.m_axi4s_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.s_axi4s_tready = ready;
  assign bus.m_axi4s_tdata  = out_data;
  assign bus.m_axi4s_tstrb  = out_strb;
  assign bus.m_axi4s_tuser  = out_user;
  assign bus.m_axi4s_tfirst = out_first;
  assign bus.m_axi4s_tlast  = out_last;
  assign bus.m_axi4s_tsel   = out_sel;
  assign bus.m_axi4s_tvalid = out_valid;
  assign busy               = (state == BUSY);

endmodule

// File: tb/tb_jelly2_axi4s_packet_arbiter.sv
// Self-checking bench: randomized packet sources, per-cycle reference model and
// per-port scoreboard for the HAS_LAST=1 instance, plus a HAS_LAST=0 instance.
// Inputs change 1 time unit after posedge; checks run on negedge.
module tb_jelly2_axi4s_packet_arbiter;

  localparam int NUM = 4, DW = 32, SW = 4, UW = 4, SELW = 2;

  logic aclk = 1'b0;
  logic aresetn, aclken, busy, busy_nl;
  always #5 aclk = ~aclk;

  jelly2_axi4s_packet_arbiter_if #(.NUM(NUM), .TDATA_WIDTH(DW), .TSTRB_WIDTH(SW),
    .TUSER_BITS(UW), .SEL_WIDTH(SELW)) bus ();
  jelly2_axi4s_packet_arbiter_if #(.NUM(NUM), .TDATA_WIDTH(DW), .TSTRB_WIDTH(SW),
    .TUSER_BITS(1), .SEL_WIDTH(SELW)) bus_nl ();

  jelly2_axi4s_packet_arbiter #(.NUM(NUM), .TDATA_WIDTH(DW), .TSTRB_WIDTH(SW),
    .TUSER_WIDTH(UW), .HAS_LAST(1'b1)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .bus(bus), .busy(busy));

  jelly2_axi4s_packet_arbiter #(.NUM(NUM), .TDATA_WIDTH(DW), .TSTRB_WIDTH(SW),
    .TUSER_WIDTH(0), .HAS_LAST(1'b0)) u_dut_nl (
    .aclk(aclk), .aresetn(aresetn), .aclken(1'b1), .bus(bus_nl), .busy(busy_nl));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  user;
    logic        last;
    int          delay;
  } beat_t;

  typedef struct {
    int sel;
    bit first;
    bit last;
    bit bsy;
    int cyc;
  } log_t;

  beat_t src_q[NUM][$];
  beat_t sb_q[NUM][$];
  log_t  out_log[$];
  bit    showing[NUM];
  int    dly[NUM];
  logic [NUM-1:0] hs;
  int    rdy_mode, rdy_ph, cyc, total_beats;
  int    errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- sources and sink driver ----------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      for (int i = 0; i < NUM; i++) begin
        if (hs[i]) begin
          if (src_q[i].size() > 0) void'(src_q[i].pop_front());
          showing[i] = 1'b0;
          dly[i] = 0;
        end
        if (src_q[i].size() == 0) begin
          showing[i] = 1'b0;
          dly[i] = 0;
        end else if (!showing[i]) begin
          if (dly[i] >= src_q[i][0].delay) showing[i] = 1'b1;
          else dly[i]++;
        end
        bus.s_axi4s_tvalid[i] = showing[i];
        if (showing[i]) begin
          bus.s_axi4s_tdata[i*DW +: DW] = src_q[i][0].data;
          bus.s_axi4s_tstrb[i*SW +: SW] = src_q[i][0].strb;
          bus.s_axi4s_tuser[i*UW +: UW] = src_q[i][0].user;
          bus.s_axi4s_tlast[i]          = src_q[i][0].last;
        end
      end
      rdy_ph++;
      case (rdy_mode)
        1:       bus.m_axi4s_tready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        2:       bus.m_axi4s_tready = 1'($urandom_range(0, 1));
        default: bus.m_axi4s_tready = 1'b1;
      endcase
    end
  end

  // ---------------- reference model + compare ----------------
  bit              mv, lock, m_first, m_last, fnd;
  int              lock_port, rr, m_sel, acc;
  logic [31:0]     m_data;
  logic [3:0]      m_strb, m_user;
  logic [NUM-1:0]  exp_rdy;
  bit              prev_stall, prev_rstn;
  logic [31:0]     prev_data;
  int              prev_sel;
  beat_t           eb;

  initial begin
    mv = 0; lock = 0; rr = 0; lock_port = 0; cyc = 0; hs = '0;
    prev_stall = 0; prev_rstn = 0;
  end

  always @(negedge aclk) begin
    cyc++;
    exp_rdy = '0;
    if (aclken && (!mv || bus.m_axi4s_tready)) begin
      if (lock) exp_rdy[lock_port] = 1'b1;
      else begin
        fnd = 0;
        for (int k = 0; k < NUM; k++)
          if (!fnd && bus.s_axi4s_tvalid[(rr + k) % NUM]) begin
            exp_rdy[(rr + k) % NUM] = 1'b1;
            fnd = 1;
          end
      end
    end
    check("s_tready", bus.s_axi4s_tready, exp_rdy);
    check("busy", busy, lock);
    check("m_tvalid", bus.m_axi4s_tvalid, mv);
    if (mv) begin
      check("m_tdata", bus.m_axi4s_tdata, m_data);
      check("m_tstrb", bus.m_axi4s_tstrb, m_strb);
      check("m_tuser", bus.m_axi4s_tuser, m_user);
      check("m_tlast", bus.m_axi4s_tlast, m_last);
      check("m_tfirst", bus.m_axi4s_tfirst, m_first);
      check("m_tsel", bus.m_axi4s_tsel, m_sel);
    end
    if (prev_stall && prev_rstn) begin
      check("stall_hold_data", bus.m_axi4s_tdata, prev_data);
      check("stall_hold_sel", bus.m_axi4s_tsel, prev_sel);
    end
    prev_stall = bus.m_axi4s_tvalid && (!bus.m_axi4s_tready || !aclken);
    prev_rstn  = aresetn;
    prev_data  = bus.m_axi4s_tdata;
    prev_sel   = int'(bus.m_axi4s_tsel);

    // downstream transfer: per-port order scoreboard
    if (aresetn && aclken && bus.m_axi4s_tvalid && bus.m_axi4s_tready) begin
      if (sb_q[bus.m_axi4s_tsel].size() == 0) begin
        check("sb_unexpected_beat", 1, 0);
      end else begin
        eb = sb_q[bus.m_axi4s_tsel].pop_front();
        check("sb_data", bus.m_axi4s_tdata, eb.data);
        check("sb_strb", bus.m_axi4s_tstrb, eb.strb);
        check("sb_last", bus.m_axi4s_tlast, eb.last);
      end
      out_log.push_back('{int'(bus.m_axi4s_tsel), bus.m_axi4s_tfirst, bus.m_axi4s_tlast, busy, cyc});
    end

    hs = bus.s_axi4s_tvalid & bus.s_axi4s_tready;

    // next model state
    if (!aresetn) begin
      mv = 0; lock = 0; rr = 0; lock_port = 0;
    end else if (aclken) begin
      acc = -1;
      for (int p = 0; p < NUM; p++) if (exp_rdy[p] && bus.s_axi4s_tvalid[p]) acc = p;
      if (acc >= 0) begin
        mv      = 1;
        m_data  = bus.s_axi4s_tdata[acc*DW +: DW];
        m_strb  = bus.s_axi4s_tstrb[acc*SW +: SW];
        m_user  = bus.s_axi4s_tuser[acc*UW +: UW];
        m_last  = bus.s_axi4s_tlast[acc];
        m_first = !lock;
        m_sel   = acc;
        if (!lock) begin
          if (!m_last) begin lock = 1; lock_port = acc; end
          else rr = (acc + 1) % NUM;
        end else if (m_last) begin
          lock = 0;
          rr = (acc + 1) % NUM;
        end
      end else if (bus.m_axi4s_tready) begin
        mv = 0;
      end
    end
  end

  // ---------------- HAS_LAST=0 instance ----------------
  int nl_n = 0;
  initial begin
    bus_nl.s_axi4s_tvalid = 4'b1001;
    bus_nl.s_axi4s_tlast  = '0;
    bus_nl.s_axi4s_tdata  = '0;
    bus_nl.s_axi4s_tstrb  = '1;
    bus_nl.s_axi4s_tuser  = '0;
    bus_nl.m_axi4s_tready = 1'b1;
  end

  always @(negedge aclk) begin
    if (aresetn && bus_nl.m_axi4s_tvalid && nl_n < 8) begin
      check("nl_tsel", bus_nl.m_axi4s_tsel, (nl_n % 2 == 0) ? 0 : 3);
      check("nl_tlast", bus_nl.m_axi4s_tlast, 1);
      check("nl_tfirst", bus_nl.m_axi4s_tfirst, 1);
      check("nl_busy", busy_nl, 0);
      nl_n++;
    end
  end

  // ---------------- directed and random sequences ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic add_packet(input int port, input int len, input int first_gap,
                            input int mid_gap, input bit rnd_gap);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = $urandom;
      b.strb  = 4'($urandom);
      b.user  = 4'($urandom);
      b.last  = (k == len - 1);
      b.delay = rnd_gap ? int'($urandom_range(0, 2)) : ((k == 0) ? first_gap : ((k == 1) ? mid_gap : 0));
      src_q[port].push_back(b);
      sb_q[port].push_back(b);
      total_beats++;
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (out_log.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    check(name, out_log.size() >= n, 1);
  endtask

  task automatic sb_empty(input string name);
    int s;
    s = 0;
    for (int i = 0; i < NUM; i++) s += sb_q[i].size();
    check(name, s, 0);
  endtask

  logic [31:0] frz_data;
  bit          frz_valid;
  int          frz_sel;

  initial begin
    aresetn = 1'b0;
    aclken  = 1'b1;
    rdy_mode = 0;
    rdy_ph = 0;
    total_beats = 0;
    bus.s_axi4s_tvalid = '0;
    bus.s_axi4s_tdata = '0;
    bus.s_axi4s_tstrb = '0;
    bus.s_axi4s_tuser = '0;
    bus.s_axi4s_tlast = '0;
    bus.m_axi4s_tready = 1'b1;
    tick(3);
    check("rst_m_tvalid", bus.m_axi4s_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_tsel", bus.m_axi4s_tsel, 0);
    check("rst_m_tdata", bus.m_axi4s_tdata, 0);
    check("rst_m_tfirst", bus.m_axi4s_tfirst, 0);
    check("rst_m_tlast", bus.m_axi4s_tlast, 0);
    aresetn = 1'b1;

    // all ports, 3-beat packets
    for (int p = 0; p < NUM; p++) begin
      add_packet(p, 3, 0, 0, 0);
      add_packet(p, 3, 0, 0, 0);
    end
    wait_log(24, 200, "t1_timeout");
    for (int k = 0; k < 13; k++) begin
      check("t1_tsel", out_log[k].sel, (k / 3) % 4);
      check("t1_tfirst", out_log[k].first, (k % 3) == 0);
    end
    check("t1_no_bubble", out_log[12].cyc - out_log[0].cyc, 12);
    tick(3);
    sb_empty("t1_drained");

    // port 2 alone, two 2-beat packets back to back
    out_log.delete();
    add_packet(2, 2, 0, 0, 0);
    add_packet(2, 2, 0, 0, 0);
    wait_log(4, 50, "t2_timeout");
    for (int k = 0; k < 4; k++) begin
      check("t2_tsel", out_log[k].sel, 2);
      check("t2_tfirst", out_log[k].first, (k % 2) == 0);
    end
    check("t2_no_bubble", out_log[3].cyc - out_log[0].cyc, 3);
    tick(3);

    // port 1 pauses mid-packet while port 0 waits
    out_log.delete();
    add_packet(1, 3, 0, 3, 0);
    add_packet(0, 1, 1, 0, 0);
    wait_log(4, 50, "t3_timeout");
    check("t3_sel0", out_log[0].sel, 1);
    check("t3_sel2", out_log[2].sel, 1);
    check("t3_sel3", out_log[3].sel, 0);
    check("t3_busy_locked", out_log[0].bsy, 1);
    check("t3_busy_fell", out_log[2].bsy, 0);
    check("t3_next_cycle", out_log[3].cyc - out_log[2].cyc, 1);
    check("t3_gap", out_log[1].cyc - out_log[0].cyc, 4);
    tick(3);

    // random packets under m_tready 1,0,0,1 then random backpressure
    for (int round = 1; round <= 2; round++) begin
      rdy_mode = round;
      out_log.delete();
      total_beats = 0;
      for (int p = 0; p < NUM; p++)
        for (int n = 0; n < 6; n++) add_packet(p, int'($urandom_range(1, 5)), 0, 0, 1);
      wait_log(total_beats, 3000, "t4_timeout");
      tick(4);
      sb_empty("t4_drained");
    end
    rdy_mode = 0;
    tick(2);

    // clock enable low mid-packet, then reset with aclken still low
    out_log.delete();
    add_packet(1, 8, 0, 0, 0);
    wait_log(2, 50, "t5_timeout");
    aclken = 1'b0;
    frz_data  = bus.m_axi4s_tdata;
    frz_valid = bus.m_axi4s_tvalid;
    frz_sel   = int'(bus.m_axi4s_tsel);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("t5_frozen_data", bus.m_axi4s_tdata, frz_data);
      check("t5_frozen_valid", bus.m_axi4s_tvalid, frz_valid);
      check("t5_frozen_sel", bus.m_axi4s_tsel, frz_sel);
      check("t5_tready_zero", bus.s_axi4s_tready, 0);
    end
    aresetn = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      src_q[i].delete();
      showing[i] = 1'b0;
    end
    tick(1);
    aresetn = 1'b1;
    for (int i = 0; i < NUM; i++) sb_q[i].delete();
    check("t5_rst_m_tvalid", bus.m_axi4s_tvalid, 0);
    check("t5_rst_busy", busy, 0);
    aclken = 1'b1;
    out_log.delete();
    for (int p = NUM - 1; p >= 0; p--) add_packet(p, 1, 0, 0, 0);
    wait_log(4, 50, "t5b_timeout");
    for (int k = 0; k < 4; k++) check("t5_post_rst_order", out_log[k].sel, k);
    tick(3);
    sb_empty("t5_drained");

    check("nl_beats_seen", nl_n, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
